s_mem_reader: RTL and testbench

//  Sequential reader for the 256x8 S memory. On start it reads addresses
//  0..255 in order, compensates for the RAM's synchronous read latency, and

---
 rtl/s_mem_reader.sv | 182 ++++++++++++++++++
 tb/tb_s_mem_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mem_reader.sv
// Sequential read-back of the 256x8 S memory: issues addresses 0..255, re-aligns
// the synchronous RAM data with its address tag, and streams beats out with an optional identity check.
//
// state | meaning
// IDLE  | waiting for start; outputs hold results of the last pass
// READ  | issuing reads while output credit is available
// DRAIN | all reads issued; waiting for in-flight reads and FIFO to empty
// DONE  | one-cycle completion pulse, then back to IDLE
module s_mem_reader #(
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       check_en,
    output logic [7:0] address,
    input  logic [7:0] q,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [8:0] mismatch_count,
    output logic [7:0] first_bad_addr
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state;
    logic [8:0]              rd_ptr;
    logic                    chk_en_q;
    logic [READ_LATENCY-1:0] sr_valid;
    logic [7:0]              sr_tag [READ_LATENCY];
    logic [7:0]              fifo_addr [FIFO_DEPTH];
    logic [7:0]              fifo_data [FIFO_DEPTH];
    logic [PW-1:0]           wr_idx;
    logic [PW-1:0]           rd_idx;
    logic [CW-1:0]           fifo_count;
    logic [CW-1:0]           fifo_count_next;
    logic [3:0]              in_flight;
    logic [3:0]              in_flight_next;
    logic [7:0]              occupancy;
    logic                    tail_valid;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    hit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + {3'b000, sr_valid[i]};
        end
    end

    assign tail_valid = sr_valid[READ_LATENCY-1];
    assign push       = tail_valid;
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign out_addr   = fifo_addr[rd_idx];
    assign out_data   = fifo_data[rd_idx];
    assign hit        = pop && chk_en_q && (out_data != out_addr);

    // Credit counts every read already issued, so the FIFO can always absorb the pipeline.
    assign occupancy  = 8'(fifo_count) + {4'b0000, in_flight};
    assign issue      = (state == READ) && (occupancy < 8'(FIFO_DEPTH));

    assign in_flight_next = in_flight - {3'b000, tail_valid} + {3'b000, issue};

    always_comb begin
        fifo_count_next = fifo_count;
        if (push && !pop) begin
            fifo_count_next = fifo_count + 1'b1;
        end else if (!push && pop) begin
            fifo_count_next = fifo_count - 1'b1;
        end
    end

    // rd_ptr reaches 256 after the last issue; the address stays parked on 255.
    assign address = rd_ptr[8] ? 8'hFF : rd_ptr[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            chk_en_q       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_count <= '0;
            first_bad_addr <= '0;
            sr_valid       <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                sr_tag[i] <= '0;
            end
            wr_idx         <= '0;
            rd_idx         <= '0;
            fifo_count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= READ;
                        busy           <= 1'b1;
                        rd_ptr         <= '0;
                        chk_en_q       <= check_en;
                        mismatch_count <= '0;
                        first_bad_addr <= '0;
                    end
                end
                READ: begin
                    if (issue && rd_ptr == 9'd255) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_count_next == '0 && in_flight_next == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (issue) begin
                rd_ptr <= rd_ptr + 9'd1;
            end

            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_tag[i]   <= sr_tag[i-1];
            end
            sr_valid[0] <= issue;
            sr_tag[0]   <= rd_ptr[7:0];

            if (push) begin
                wr_idx <= ptr_inc(wr_idx);
            end
            if (pop) begin
                rd_idx <= ptr_inc(rd_idx);
            end
            fifo_count <= fifo_count_next;

            if (hit) begin
                mismatch_count <= mismatch_count + 9'd1;
                if (mismatch_count == '0) begin
                    first_bad_addr <= out_addr;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= sr_tag[READ_LATENCY-1];
            fifo_data[wr_idx] <= q;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && fifo_count == CW'(FIFO_DEPTH)));
        end
    end

endmodule

// File: tb/tb_s_mem_reader.sv
// Randomized bench for s_mem_reader: two instances (latency 1/depth 4 and
// latency 2/depth 3) checked against an expected-beat model derived from a RAM image.
module tb_s_mem_reader;

    logic clk = 1'b0;
    logic rst, start, check_en, out_ready, sel;
    logic [7:0] ram [256];

    logic [7:0] addr_a, q_a, oa_a, od_a, fb_a;
    logic       ov_a, busy_a, done_a;
    logic [8:0] mc_a;
    logic [7:0] addr_b, q_b, qb_1, oa_b, od_b, fb_b;
    logic       ov_b, busy_b, done_b;
    logic [8:0] mc_b;
    logic       start_a, start_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    s_mem_reader #(.READ_LATENCY(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .check_en(check_en),
        .address(addr_a), .q(q_a), .out_addr(oa_a), .out_data(od_a),
        .out_valid(ov_a), .out_ready(out_ready), .busy(busy_a), .done(done_a),
        .mismatch_count(mc_a), .first_bad_addr(fb_a)
    );

    s_mem_reader #(.READ_LATENCY(2), .FIFO_DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .check_en(check_en),
        .address(addr_b), .q(q_b), .out_addr(oa_b), .out_data(od_b),
        .out_valid(ov_b), .out_ready(out_ready), .busy(busy_b), .done(done_b),
        .mismatch_count(mc_b), .first_bad_addr(fb_b)
    );

    // Synchronous RAM models with one and two cycles of read latency
    always @(posedge clk) q_a <= ram[addr_a];
    always @(posedge clk) begin
        qb_1 <= ram[addr_b];
        q_b  <= qb_1;
    end

    wire [7:0] o_address = sel ? addr_b : addr_a;
    wire [7:0] o_addr    = sel ? oa_b   : oa_a;
    wire [7:0] o_data    = sel ? od_b   : od_a;
    wire       o_valid   = sel ? ov_b   : ov_a;
    wire       o_busy    = sel ? busy_b : busy_a;
    wire       o_done    = sel ? done_b : done_a;
    wire [8:0] o_mc      = sel ? mc_b   : mc_a;
    wire [7:0] o_fb      = sel ? fb_b   : fb_a;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_mismatches(input bit chk);
        int c = 0;
        if (chk) begin
            for (int i = 0; i < 256; i++) if (ram[i] != 8'(i)) c++;
        end
        return c;
    endfunction

    function automatic int exp_first_bad(input bit chk);
        if (chk) begin
            for (int i = 0; i < 256; i++) if (ram[i] != 8'(i)) return i;
        end
        return 0;
    endfunction

    task automatic ram_identity();
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    endtask

    task automatic ram_random();
        for (int i = 0; i < 256; i++) ram[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(i);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ready_mode: 0 always ready, 1 random, 2 random plus a 20-cycle stall at beat 100
    task automatic run_pass(input int lat, input int depth, input bit chk, input int ready_mode,
                            input bit hold, input int pulse_at, input int abort_at);
        int n, accepted, first_valid, done_cyc, last_hs, hold_left, bad_adv;
        logic v, rdy, stalled;
        logic [7:0] pa, pd;
        check_en = chk;
        start = 1'b1;
        n = 0; accepted = 0; first_valid = -1; done_cyc = -1; last_hs = -1;
        hold_left = 20; bad_adv = 0; stalled = 1'b0; pa = '0; pd = '0;
        while (done_cyc < 0 && n < 3000) begin
            next_cycle();
            n++;
            start = hold || (n == pulse_at);
            check_en = 1'($urandom_range(0, 1));
            if (n == 1) chk_eq("busy_in_read", 32'(o_busy), 1);
            if (abort_at >= 0 && accepted == abort_at) begin
                rst = 1'b1;
                #1;
                chk_eq("abort_valid", 32'(o_valid), 0);
                chk_eq("abort_busy", 32'(o_busy), 0);
                chk_eq("abort_done", 32'(o_done), 0);
                chk_eq("abort_address", 32'(o_address), 0);
                chk_eq("abort_count", 32'(o_mc), 0);
                chk_eq("abort_first_bad", 32'(o_fb), 0);
                for (int k = 0; k < 3; k++) begin
                    next_cycle();
                    chk_eq("abort_no_done", 32'(o_done), 0);
                end
                rst = 1'b0;
                start = 1'b0;
                return;
            end
            if (stalled) begin
                chk_eq("stall_valid", 32'(o_valid), 1);
                chk_eq("stall_addr", 32'(o_addr), 32'(pa));
                chk_eq("stall_data", 32'(o_data), 32'(pd));
            end
            v = o_valid;
            if (v && first_valid < 0) first_valid = n;
            if (int'(o_address) > accepted + depth) bad_adv++;
            if (o_done) begin
                done_cyc = n;
                chk_eq("done_busy", 32'(o_busy), 0);
                chk_eq("done_valid", 32'(o_valid), 0);
            end else begin
                case (ready_mode)
                    0:       rdy = 1'b1;
                    default: rdy = ($urandom_range(0, 3) != 0);
                endcase
                if (ready_mode == 2 && accepted == 100 && hold_left > 0) begin
                    rdy = 1'b0;
                    hold_left--;
                end
                out_ready = rdy;
                if (v && rdy) begin
                    if (accepted < 256) begin
                        chk_eq("beat_addr", 32'(o_addr), 32'(accepted));
                        chk_eq("beat_data", 32'(o_data), 32'(ram[accepted]));
                    end else begin
                        chk_eq("extra_beat", 32'(accepted), 255);
                    end
                    accepted++;
                    last_hs = n;
                end
                stalled = v && !rdy;
                pa = o_addr;
                pd = o_data;
            end
        end
        chk_eq("pass_timeout", 32'(done_cyc >= 0), 1);
        chk_eq("beat_total", 32'(accepted), 256);
        chk_eq("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
        chk_eq("addr_adv_bound", 32'(bad_adv), 0);
        if (ready_mode == 0) chk_eq("first_valid_cycle", 32'(first_valid), 32'(lat + 2));
        if (ready_mode == 0 && lat == 1) chk_eq("done_cycle", 32'(done_cyc), 32'(256 + lat + 2));
        chk_eq("mismatch_count", 32'(o_mc), 32'(exp_mismatches(chk)));
        chk_eq("first_bad_addr", 32'(o_fb), 32'(exp_first_bad(chk)));
    endtask

    task automatic check_quiet(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            next_cycle();
            chk_eq("quiet_valid", 32'(o_valid), 0);
            chk_eq("quiet_busy", 32'(o_busy), 0);
            chk_eq("quiet_done", 32'(o_done), 0);
        end
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; start = 1'b0; check_en = 1'b0; out_ready = 1'b0;
        ram_identity();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk_eq("rst_address", 32'(o_address), 0);
            chk_eq("rst_valid", 32'(o_valid), 0);
            chk_eq("rst_busy", 32'(o_busy), 0);
            chk_eq("rst_done", 32'(o_done), 0);
            chk_eq("rst_count", 32'(o_mc), 0);
            chk_eq("rst_first_bad", 32'(o_fb), 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        run_pass(1, 4, 1'b1, 0, 1'b0, -1, -1);
        check_quiet(2);

        ram[7] = 8'hFF;
        ram[200] = 8'h00;
        run_pass(1, 4, 1'b1, 0, 1'b0, -1, -1);
        next_cycle();
        run_pass(1, 4, 1'b0, 1, 1'b0, -1, -1);
        next_cycle();

        ram_random();
        run_pass(1, 4, 1'b1, 2, 1'b0, -1, -1);
        next_cycle();
        ram_random();
        run_pass(1, 4, 1'b1, 1, 1'b0, -1, -1);
        next_cycle();

        ram_identity();
        ram[7] = 8'hFF;
        run_pass(1, 4, 1'b1, 1, 1'b0, -1, 50);
        next_cycle();
        ram_identity();
        run_pass(1, 4, 1'b1, 0, 1'b0, -1, -1);
        next_cycle();

        run_pass(1, 4, 1'b1, 0, 1'b0, 50, -1);
        check_quiet(2);
        run_pass(1, 4, 1'b1, 0, 1'b1, -1, -1);
        next_cycle();
        chk_eq("idle_gap_busy", 32'(o_busy), 0);
        chk_eq("idle_gap_done", 32'(o_done), 0);
        ram_random();
        run_pass(1, 4, 1'b1, 0, 1'b1, -1, -1);
        start = 1'b0;
        next_cycle();
        check_quiet(4);

        sel = 1'b1;
        ram_identity();
        run_pass(2, 3, 1'b1, 0, 1'b0, -1, -1);
        next_cycle();
        ram_random();
        run_pass(2, 3, 1'b1, 2, 1'b0, -1, -1);
        check_quiet(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
